apb_master: RTL
===============

// Module: apb_master
// PURPOSE
//   APB requester (bridge side) for the APB slave memory. It accepts one command at a time
//   through a valid/ready port and runs the APB SETUP then ACCESS phases. It waits for
//   pready_i, subject to a wait-state timeout, then returns a one-cycle response pulse.
//   It sits between a local command source (CPU/testbench/DMA) and APB slaves.
// PARAMETERS
//   ADDR_W   10  APB address width
//   DATA_W   32  APB data width
//   TIMEOUT  15  max ACCESS cycles before abort; 0 = no timeout; legal range 0..255
// PORTS
//   clk          in   1       single clock, all logic on posedge
//   reset        in   1       asynchronous, active-low reset (0 = in reset)
//   cmd_valid_i  in   1       command request; held until accepted
//   cmd_ready_o  out  1       command accepted when cmd_valid_i & cmd_ready_o at posedge
//   cmd_write_i  in   1       1 = write, 0 = read
//   cmd_addr_i   in   ADDR_W  transfer address
//   cmd_wdata_i  in   DATA_W  write data (ignored for reads)
//   rsp_valid_o  out  1       one-cycle response pulse; no back-pressure
//   rsp_rdata_o  out  DATA_W  read data; 0 for writes and for timeouts
//   rsp_err_o    out  1       1 = transfer aborted by timeout; qualified by rsp_valid_o
//   psel_o       out  1       APB select
//   penable_o    out  1       APB enable (ACCESS phase)
//   pwrite_o     out  1       APB direction
//   paddr_o      out  ADDR_W  APB address
//   pwdata_o     out  DATA_W  APB write data
//   prdata_i     in   DATA_W  APB read data, sampled only on completion
//   pready_i     in   1       APB ready from slave
// BEHAVIOUR
//   Reset (reset=0, immediate): FSM state=IDLE. psel_o, penable_o, pwrite_o, paddr_o,
//     pwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o and the wait counter are all 0.
//     cmd_ready_o = (state==IDLE) & reset, so it is 0 while reset is low.
//   FSM, all APB outputs registered:
//     IDLE: cmd_ready_o=1, psel=0, penable=0. On accept: latch write/addr/wdata into
//       pwrite_o/paddr_o/pwdata_o -> SETUP.
//     SETUP (exactly 1 cycle): psel=1, penable=0. Clear wait counter -> ACCESS.
//     ACCESS: psel=1, penable=1.
//       pready_i=1: transfer completes -> IDLE. If read, capture prdata_i.
//       pready_i=0: increment wait counter. If TIMEOUT!=0 and counter==TIMEOUT-1: abort -> IDLE.
//       ACCESS therefore lasts at most TIMEOUT cycles.
//       pready_i=1 in the final allowed cycle completes normally; no error.
//   Address, direction and write data are stable from SETUP through the end of ACCESS.
//     They hold their last value in IDLE.
//   Response:
//     rsp_valid_o=1 for exactly the one cycle after ACCESS ends, i.e. the first IDLE cycle.
//     Normal completion: rsp_err_o=0; rsp_rdata_o = captured prdata_i for reads, 0 for writes.
//     Timeout: rsp_err_o=1, rsp_rdata_o=0.
//     rsp_rdata_o and rsp_err_o return to 0 when rsp_valid_o falls.
//   Latency: accept at edge N -> SETUP in cycle N+1 -> ACCESS from cycle N+2 -> rsp_valid_o
//     in the cycle after pready_i. Zero-wait transfer: accept to rsp_valid_o = 3 cycles.
//   Back-to-back: cmd_ready_o=1 in the same IDLE cycle that rsp_valid_o pulses.
//     Sustained zero-wait throughput is 1 transfer / 3 cycles.
//     psel_o drops for at least that one IDLE cycle between transfers.
//   cmd_valid_i while busy: cmd_ready_o=0; the command is not consumed and its fields are not sampled.
//   pready_i in IDLE or SETUP is ignored.
//   Reset mid-transfer: APB outputs drop to 0 immediately. The in-flight command is lost.
//     No rsp_valid_o is issued after reset release.
// TESTING
//   1. Write 0x005 <- 0xDEADBEEF, slave adds 3 wait states -> psel_o rises 1 cycle after
//      accept, penable_o 1 cycle later for 4 cycles, rsp_valid_o 1 cycle, rsp_err_o=0.
//   2. Read 0x005 from the same slave -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0;
//      paddr_o=0x005 and pwrite_o=0 stable during SETUP+ACCESS.
//   3. TIMEOUT=4, pready_i tied 0 -> penable_o high exactly 4 cycles, then rsp_valid_o=1,
//      rsp_err_o=1, rsp_rdata_o=0. Repeat with pready_i=1 in the 4th cycle -> rsp_err_o=0.
//   4. Two commands presented back-to-back, zero-wait slave -> second accepted in the cycle
//      where the first rsp_valid_o pulses; psel_o low exactly 1 cycle between transfers.
//   5. Drive reset=0 in the 2nd ACCESS cycle -> psel_o/penable_o 0 without waiting for clk.
//      After release: no rsp_valid_o, cmd_ready_o=1 on the first cycle.
//   6. cmd_valid_i held high with changing addr while busy -> cmd_ready_o=0 throughout.
//      paddr_o keeps the originally latched value.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: takes one command at a time on a valid/ready port, runs SETUP then ACCESS,
// and returns a one-cycle response pulse carrying read data or a wait-state timeout error.
module apb_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Counter value in the last ACCESS cycle the slave is allowed before we abort.
  localparam logic [7:0] WCNT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WCNT_LAST);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wcnt_d    = 8'd0;
      end
      ACCESS: begin
        if (pready_i) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          if (timeout_hit) begin
            state_d     = IDLE;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= 8'd0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  assign cmd_ready_o = (state_q == IDLE) && reset;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;

endmodule
